// File: rtl/led_pulse_driver_if.sv
// Event-in / LED-out bundle for led_pulse_driver.
// Combinational bundle with no latency of its own.
// Events have no backpressure; overflow is reported through OVF.
//
// Ports:
//   CE       tick strobe from the driving side; advances on/gap timing
//   EVT_IN   event pulse; each high cycle counts as one event
//   LED_OUT  registered LED drive, high while a blink is on
//   BUSY     high while a blink or its off-gap is in progress
//   PEND_CNT queued events not yet started
//   OVF      sticky, set when an event is dropped at saturation
interface led_pulse_driver_if #(
    parameter int PEND_WIDTH = 3
) ();
    logic                  CE;
    logic                  EVT_IN;
    logic                  LED_OUT;
    logic                  BUSY;
    logic [PEND_WIDTH-1:0] PEND_CNT;
    logic                  OVF;

    // Event source side (debouncer / PWM control, or the bench).
    modport master (
        output CE,
        output EVT_IN,
        input  LED_OUT,
        input  BUSY,
        input  PEND_CNT,
        input  OVF
    );

    // Pulse driver side.
    modport slave (
        input  CE,
        input  EVT_IN,
        output LED_OUT,
        output BUSY,
        output PEND_CNT,
        output OVF
    );
endinterface

// File: rtl/led_pulse_driver.sv
// Stretches single-cycle events into ON_TICKS-long LED blinks, each followed by an OFF_TICKS gap.
// Event -> PEND_CNT in 1 CLK; event -> LED_OUT high in 2 CLK when idle.
// Events are never stalled: they queue in a saturating counter and a sticky OVF flags drops.
//
// Ports:
//   CLK  system clock, rising edge
//   RST  asynchronous, active-high reset
//   bus  led_pulse_driver_if.slave (CE, EVT_IN in; LED_OUT, BUSY, PEND_CNT, OVF out)
module led_pulse_driver #(
    parameter int CNTR_WIDTH = 4,
    parameter int ON_TICKS   = 8,
    parameter int OFF_TICKS  = 8,
    parameter int PEND_WIDTH = 3
) (
    input  logic               CLK,
    input  logic               RST,
    led_pulse_driver_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Terminal counts; a period of 2^CNTR_WIDTH ticks lands on all-ones,
    // so the counter never has to wrap.
    localparam logic [CNTR_WIDTH-1:0] ON_LAST  = CNTR_WIDTH'(ON_TICKS - 1);
    localparam logic [CNTR_WIDTH-1:0] OFF_LAST = CNTR_WIDTH'(OFF_TICKS - 1);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = {PEND_WIDTH{1'b1}};

    state_t                state_q, state_d;
    logic [CNTR_WIDTH-1:0] tcnt_q,  tcnt_d;
    logic [PEND_WIDTH-1:0] pend_q,  pend_d;
    logic                  ovf_q,   ovf_d;
    logic                  led_q,   led_d;
    logic                  start;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        // A blink can only start from IDLE, which guarantees at least one
        // IDLE cycle between consecutive blinks.
        start   = (state_q == ST_IDLE) && (pend_q != '0);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ON;
                    tcnt_d  = '0;
                end
            end
            ST_ON: begin
                if (bus.CE) begin
                    if (tcnt_q == ON_LAST) begin
                        state_d = ST_GAP;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (bus.CE) begin
                    if (tcnt_q == OFF_LAST) begin
                        state_d = ST_IDLE;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tcnt_d  = '0;
            end
        endcase

        // Pending queue: a simultaneous event and start cancel out. start
        // implies pend_q > 0, so the decrement cannot underflow.
        case ({bus.EVT_IN, start})
            2'b10: begin
                if (pend_q == PEND_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d = pend_q + 1'b1;
                end
            end
            2'b01:   pend_d = pend_q - 1'b1;
            default: pend_d = pend_q;
        endcase

        // Registered LED tracks the ON state exactly.
        led_d = (state_d == ST_ON);
    end

    assign bus.LED_OUT  = led_q;
    assign bus.BUSY     = (state_q != ST_IDLE);
    assign bus.PEND_CNT = pend_q;
    assign bus.OVF      = ovf_q;

endmodule

// File: tb/tb_led_pulse_driver.sv
// Directed bench for led_pulse_driver: two instances (4-bit counter, and a 2-bit counter at its limit).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Cycle c of a test is the clock period whose inputs were driven by the c-th call of step.
module tb_led_pulse_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    led_pulse_driver_if #(.PEND_WIDTH(2)) ifa ();
    led_pulse_driver_if #(.PEND_WIDTH(2)) ifb ();

    led_pulse_driver #(
        .CNTR_WIDTH(4), .ON_TICKS(4), .OFF_TICKS(2), .PEND_WIDTH(2)
    ) dut_a (
        .CLK(clk), .RST(rst), .bus(ifa)
    );

    led_pulse_driver #(
        .CNTR_WIDTH(2), .ON_TICKS(4), .OFF_TICKS(1), .PEND_WIDTH(2)
    ) dut_b (
        .CLK(clk), .RST(rst), .bus(ifb)
    );

    // sel=0 drives instance A, sel=1 drives instance B; the other sits quiet.
    task automatic step(input logic ce, input logic evt, input logic sel);
        @(posedge clk);
        #1;
        ifa.CE     = sel ? 1'b0 : ce;
        ifa.EVT_IN = sel ? 1'b0 : evt;
        ifb.CE     = sel ? ce   : 1'b0;
        ifb.EVT_IN = sel ? evt  : 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        ifa.CE = 1'b0; ifa.EVT_IN = 1'b0;
        ifb.CE = 1'b0; ifb.EVT_IN = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        ifa.CE = 1'b0; ifa.EVT_IN = 1'b0;
        ifb.CE = 1'b0; ifb.EVT_IN = 1'b0;
        rst = 1'b1;
        #3;
        total++;
        if ({ifa.LED_OUT, ifa.BUSY, ifa.PEND_CNT, ifa.OVF} !== 5'b0) begin
            bad++;
            $display("FAIL reset_a got=%b exp=00000", {ifa.LED_OUT, ifa.BUSY, ifa.PEND_CNT, ifa.OVF});
        end
        total++;
        if ({ifb.LED_OUT, ifb.BUSY, ifb.PEND_CNT, ifb.OVF} !== 5'b0) begin
            bad++;
            $display("FAIL reset_b got=%b exp=00000", {ifb.LED_OUT, ifb.BUSY, ifb.PEND_CNT, ifb.OVF});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        logic exp_led, exp_busy;
        reset_dut();
        for (int c = 0; c <= 25; c++) begin
            step(1'b1, c == 10, 1'b0);
            exp_led  = (c >= 12 && c <= 15);
            exp_busy = (c >= 12 && c <= 17);
            total++;
            if (ifa.LED_OUT !== exp_led) begin
                bad++;
                $display("FAIL single_led c=%0d got=%b exp=%b", c, ifa.LED_OUT, exp_led);
            end
            total++;
            if (ifa.BUSY !== exp_busy) begin
                bad++;
                $display("FAIL single_busy c=%0d got=%b exp=%b", c, ifa.BUSY, exp_busy);
            end
            total++;
            if (ifa.OVF !== 1'b0) begin
                bad++;
                $display("FAIL single_ovf c=%0d got=%b exp=0", c, ifa.OVF);
            end
            if (c == 11) begin
                total++;
                if (ifa.PEND_CNT !== 2'd1) begin
                    bad++;
                    $display("FAIL single_pend c=%0d got=%0d exp=1", c, ifa.PEND_CNT);
                end
            end
        end
    endtask

    task automatic test_burst_overflow();
        logic exp_led, exp_ovf, prev;
        int   rises;
        logic [1:0] exp_pend [4];
        exp_pend[0] = 2'd1; exp_pend[1] = 2'd1; exp_pend[2] = 2'd2; exp_pend[3] = 2'd3;
        rises = 0;
        prev  = 1'b0;
        reset_dut();
        for (int c = 0; c <= 45; c++) begin
            step(1'b1, (c >= 10 && c <= 14), 1'b0);
            exp_led = 1'b0;
            for (int r = 12; r <= 33; r += 7) begin
                if (c >= r && c <= r + 3) exp_led = 1'b1;
            end
            exp_ovf = (c >= 15);
            total++;
            if (ifa.LED_OUT !== exp_led) begin
                bad++;
                $display("FAIL burst_led c=%0d got=%b exp=%b", c, ifa.LED_OUT, exp_led);
            end
            total++;
            if (ifa.OVF !== exp_ovf) begin
                bad++;
                $display("FAIL burst_ovf c=%0d got=%b exp=%b", c, ifa.OVF, exp_ovf);
            end
            if (c >= 11 && c <= 14) begin
                total++;
                if (ifa.PEND_CNT !== exp_pend[c-11]) begin
                    bad++;
                    $display("FAIL burst_pend c=%0d got=%0d exp=%0d", c, ifa.PEND_CNT, exp_pend[c-11]);
                end
            end
            if (ifa.LED_OUT === 1'b1 && prev === 1'b0) rises++;
            prev = ifa.LED_OUT;
        end
        total++;
        if (rises !== 4) begin
            bad++;
            $display("FAIL burst_blinks got=%0d exp=4", rises);
        end
        total++;
        if (ifa.PEND_CNT !== 2'd0 || ifa.BUSY !== 1'b0) begin
            bad++;
            $display("FAIL burst_drain pend=%0d busy=%b exp pend=0 busy=0", ifa.PEND_CNT, ifa.BUSY);
        end
    endtask

    task automatic test_ce_gating();
        logic exp_led, ce;
        int   hi_cycles, strobes;
        hi_cycles = 0;
        strobes   = 0;
        reset_dut();
        for (int c = 0; c <= 35; c++) begin
            ce = (c % 3 == 2);
            step(ce, c == 10, 1'b0);
            // Strobes fall on 14, 17, 20, 23 during ON; gap strobes 26, 29.
            exp_led = (c >= 12 && c <= 23);
            total++;
            if (ifa.LED_OUT !== exp_led) begin
                bad++;
                $display("FAIL ce_led c=%0d got=%b exp=%b", c, ifa.LED_OUT, exp_led);
            end
            if (ifa.LED_OUT === 1'b1) begin
                hi_cycles++;
                if (ce) strobes++;
            end
        end
        total++;
        if (hi_cycles !== 12) begin
            bad++;
            $display("FAIL ce_on_clks got=%0d exp=12", hi_cycles);
        end
        total++;
        if (strobes !== 4) begin
            bad++;
            $display("FAIL ce_on_strobes got=%0d exp=4", strobes);
        end
        total++;
        if (ifa.BUSY !== 1'b0) begin
            bad++;
            $display("FAIL ce_end_busy got=%b exp=0", ifa.BUSY);
        end
    endtask

    task automatic test_reset_mid_blink();
        reset_dut();
        for (int c = 0; c <= 13; c++) begin
            step(1'b1, (c >= 10 && c <= 12), 1'b0);
        end
        total++;
        if (ifa.LED_OUT !== 1'b1 || ifa.PEND_CNT !== 2'd2) begin
            bad++;
            $display("FAIL rstmid_pre led=%b pend=%0d exp led=1 pend=2", ifa.LED_OUT, ifa.PEND_CNT);
        end
        // Assert between edges: outputs must clear with no clock edge.
        rst = 1'b1;
        #1;
        total++;
        if (ifa.LED_OUT !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_led got=%b exp=0", ifa.LED_OUT);
        end
        total++;
        if (ifa.BUSY !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_busy got=%b exp=0", ifa.BUSY);
        end
        total++;
        if (ifa.PEND_CNT !== 2'd0) begin
            bad++;
            $display("FAIL rstmid_pend got=%0d exp=0", ifa.PEND_CNT);
        end
        total++;
        if (ifa.OVF !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_ovf got=%b exp=0", ifa.OVF);
        end
        #1 rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step(1'b1, 1'b0, 1'b0);
            total++;
            if ({ifa.LED_OUT, ifa.BUSY, ifa.PEND_CNT} !== 4'b0) begin
                bad++;
                $display("FAIL rstmid_after c=%0d got=%b exp=0000", c, {ifa.LED_OUT, ifa.BUSY, ifa.PEND_CNT});
            end
        end
    endtask

    task automatic test_event_at_gap_end();
        logic exp_led, exp_busy;
        reset_dut();
        for (int c = 0; c <= 30; c++) begin
            step(1'b1, (c == 10 || c == 17), 1'b0);
            exp_led  = (c >= 12 && c <= 15) || (c >= 19 && c <= 22);
            exp_busy = (c >= 12 && c <= 17) || (c >= 19 && c <= 24);
            total++;
            if (ifa.LED_OUT !== exp_led) begin
                bad++;
                $display("FAIL gapevt_led c=%0d got=%b exp=%b", c, ifa.LED_OUT, exp_led);
            end
            total++;
            if (ifa.BUSY !== exp_busy) begin
                bad++;
                $display("FAIL gapevt_busy c=%0d got=%b exp=%b", c, ifa.BUSY, exp_busy);
            end
            if (c == 18) begin
                total++;
                if (ifa.PEND_CNT !== 2'd1) begin
                    bad++;
                    $display("FAIL gapevt_pend c=%0d got=%0d exp=1", c, ifa.PEND_CNT);
                end
            end
        end
    endtask

    task automatic test_wide_counter_limit();
        logic exp_led, exp_busy;
        reset_dut();
        for (int c = 0; c <= 28; c++) begin
            step(1'b1, (c == 10 || c == 11), 1'b1);
            exp_led  = (c >= 12 && c <= 15) || (c >= 18 && c <= 21);
            exp_busy = (c >= 12 && c <= 16) || (c >= 18 && c <= 22);
            total++;
            if (ifb.LED_OUT !== exp_led) begin
                bad++;
                $display("FAIL wide_led c=%0d got=%b exp=%b", c, ifb.LED_OUT, exp_led);
            end
            total++;
            if (ifb.BUSY !== exp_busy) begin
                bad++;
                $display("FAIL wide_busy c=%0d got=%b exp=%b", c, ifb.BUSY, exp_busy);
            end
            if (c == 12) begin
                total++;
                if (ifb.PEND_CNT !== 2'd1) begin
                    bad++;
                    $display("FAIL wide_pend c=%0d got=%0d exp=1", c, ifb.PEND_CNT);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_overflow();
        test_ce_gating();
        test_reset_mid_blink();
        test_event_at_gap_end();
        test_wide_counter_limit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
